// File: rtl/halloween_op_pkg.sv
// halloween_op_pkg: opcode classes, opcode values, FSM states and colour encodings
package halloween_op_pkg;
    localparam logic [1:0] CLS_SYS    = 2'b00;
    localparam logic [1:0] CLS_COLOR  = 2'b01;
    localparam logic [1:0] CLS_SOUND  = 2'b10;
    localparam logic [1:0] CLS_EFFECT = 2'b11;

    localparam logic [3:0] ON        = 4'b0000;
    localparam logic [3:0] RESET     = 4'b0001;
    localparam logic [3:0] GREEN     = 4'b0100;
    localparam logic [3:0] PURPLE    = 4'b0101;
    localparam logic [3:0] ORANGE    = 4'b0110;
    localparam logic [3:0] SCREAMING = 4'b1000;
    localparam logic [3:0] CACKLING  = 4'b1001;
    localparam logic [3:0] BOO       = 4'b1010;
    localparam logic [3:0] WAVEHANDS = 4'b1100;
    localparam logic [3:0] MOVEJAW   = 4'b1101;
    localparam logic [3:0] FOG       = 4'b1110;

    localparam logic [2:0] COL_DARK   = 3'b000;
    localparam logic [2:0] COL_GREEN  = 3'b001;
    localparam logic [2:0] COL_PURPLE = 3'b010;
    localparam logic [2:0] COL_ORANGE = 3'b100;

    typedef enum logic [1:0] {S_OFF, S_IDLE, S_SOUND, S_EFFECT} state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/opcode_executor_action_timer.sv
// action_timer: loadable down-counter; done is high while the count sits at zero
module action_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         tick_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? value_i : (tick_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/opcode_executor.sv
// opcode_executor: accepts decoration opcodes over valid/ready and drives lights, sound and effects
module opcode_executor
    import halloween_op_pkg::*;
#(
    parameter int SOUND_LEN  = 4,
    parameter int EFFECT_LEN = 3,
    parameter int FOG_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [3:0] opcode,
    output logic       op_ready,
    output logic       powered,
    output logic [2:0] color,
    output logic       sound_on,
    output logic [1:0] sound_sel,
    output logic       wave,
    output logic       jaw,
    output logic       fog,
    output logic       bad_op
);
    localparam int TW = $clog2(max3(SOUND_LEN, EFFECT_LEN, FOG_LEN)) + 1;

    state_t     state_q, state_d;
    logic       ready_q, ready_d;
    logic       powered_q, powered_d;
    logic [2:0] color_q, color_d;
    logic       sound_on_q, sound_on_d;
    logic [1:0] sound_sel_q, sound_sel_d;
    logic       wave_q, wave_d, jaw_q, jaw_d, fog_q, fog_d;
    logic       bad_q, bad_d;
    logic       acc, legal, busy, done, load;
    logic [TW-1:0] load_val;

    assign acc   = op_valid & ready_q;
    assign legal = !(opcode inside {4'b0010, 4'b0011, 4'b0111, 4'b1011, 4'b1111});
    assign busy  = (state_q == S_SOUND) || (state_q == S_EFFECT);
    assign load  = acc && legal && (state_q == S_IDLE) && opcode[3];
    assign load_val = (opcode == FOG) ? TW'(FOG_LEN - 1) :
                      (opcode[3:2] == CLS_SOUND) ? TW'(SOUND_LEN - 1) : TW'(EFFECT_LEN - 1);

    action_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .value_i (load_val),
        .tick_i  (busy),
        .done_o  (done)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= S_OFF;
            ready_q     <= 1'b1;
            powered_q   <= 1'b0;
            color_q     <= COL_DARK;
            sound_on_q  <= 1'b0;
            sound_sel_q <= 2'b00;
            wave_q      <= 1'b0;
            jaw_q       <= 1'b0;
            fog_q       <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            powered_q   <= powered_d;
            color_q     <= color_d;
            sound_on_q  <= sound_on_d;
            sound_sel_q <= sound_sel_d;
            wave_q      <= wave_d;
            jaw_q       <= jaw_d;
            fog_q       <= fog_d;
            bad_q       <= bad_d;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:   state_d = (acc && opcode == ON) ? S_IDLE : S_OFF;
            S_IDLE:  if (acc && legal)
                         state_d = (opcode == RESET) ? S_OFF :
                                   (opcode[3:2] == CLS_SOUND) ? S_SOUND :
                                   (opcode[3:2] == CLS_EFFECT) ? S_EFFECT : S_IDLE;
            default: state_d = done ? S_IDLE : state_q;
        endcase
        ready_d = (state_d == S_OFF) || (state_d == S_IDLE);
    end

    always_comb begin
        powered_d   = powered_q;
        color_d     = color_q;
        sound_on_d  = sound_on_q;
        sound_sel_d = sound_sel_q;
        wave_d      = wave_q;
        jaw_d       = jaw_q;
        fog_d       = fog_q;
        bad_d       = 1'b0;
        case (state_q)
            S_OFF:  if (acc && opcode == ON) powered_d = 1'b1;
            S_IDLE: if (acc)
                case (opcode)
                    ON: ;
                    RESET: begin
                        powered_d   = 1'b0;
                        color_d     = COL_DARK;
                        sound_sel_d = 2'b00;
                    end
                    GREEN:  color_d = COL_GREEN;
                    PURPLE: color_d = COL_PURPLE;
                    ORANGE: color_d = COL_ORANGE;
                    SCREAMING, CACKLING, BOO: begin
                        sound_on_d  = 1'b1;
                        sound_sel_d = opcode[1:0];
                    end
                    WAVEHANDS: wave_d = 1'b1;
                    MOVEJAW:   jaw_d  = 1'b1;
                    FOG:       fog_d  = 1'b1;
                    default:   bad_d  = 1'b1;
                endcase
            default: if (done) begin
                sound_on_d = 1'b0;
                wave_d     = 1'b0;
                jaw_d      = 1'b0;
                fog_d      = 1'b0;
            end
        endcase
    end

    assign op_ready  = ready_q;
    assign powered   = powered_q;
    assign color     = color_q;
    assign sound_on  = sound_on_q;
    assign sound_sel = sound_sel_q;
    assign wave      = wave_q;
    assign jaw       = jaw_q;
    assign fog       = fog_q;
    assign bad_op    = bad_q;
endmodule

// File: tb/tb_opcode_executor.sv
// tb_opcode_executor: directed opcode sequences with hand-computed expected outputs
module tb_opcode_executor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [3:0] opcode = 4'b0000;
    logic       op_ready, powered, sound_on, wave, jaw, fog, bad_op;
    logic [2:0] color;
    logic [1:0] sound_sel;
    int total = 0;
    int bad = 0;

    opcode_executor dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .opcode    (opcode),
        .op_ready  (op_ready),
        .powered   (powered),
        .color     (color),
        .sound_on  (sound_on),
        .sound_sel (sound_sel),
        .wave      (wave),
        .jaw       (jaw),
        .fog       (fog),
        .bad_op    (bad_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op);
        op_valid = 1'b1;
        opcode   = op;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_powered", 8'(powered), 8'd0);
        chk("rst_color", 8'(color), 8'd0);
        chk("rst_ready", 8'(op_ready), 8'd1);
        chk("rst_sound", 8'({sound_on, sound_sel, wave, jaw, fog, bad_op}), 8'd0);

        send(4'b0101);
        chk("off_color", 8'(color), 8'd0);
        chk("off_powered", 8'(powered), 8'd0);
        chk("off_bad", 8'(bad_op), 8'd0);

        send(4'b0000);
        chk("on_powered", 8'(powered), 8'd1);
        chk("on_ready", 8'(op_ready), 8'd1);
        send(4'b0110);
        chk("orange", 8'(color), 8'b100);
        chk("orange_ready", 8'(op_ready), 8'd1);

        send(4'b1001);
        opcode = 4'b0100;
        chk("snd1_on", 8'(sound_on), 8'd1);
        chk("snd1_sel", 8'(sound_sel), 8'b01);
        chk("snd1_ready", 8'(op_ready), 8'd0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk($sformatf("snd%0d_on", i), 8'(sound_on), 8'd1);
            chk($sformatf("snd%0d_ready", i), 8'(op_ready), 8'd0);
            chk($sformatf("snd%0d_color", i), 8'(color), 8'b100);
        end
        step();
        chk("snd_end_on", 8'(sound_on), 8'd0);
        chk("snd_end_ready", 8'(op_ready), 8'd1);
        chk("snd_end_color", 8'(color), 8'b100);
        step();
        chk("queued_green", 8'(color), 8'b001);

        send(4'b1010);
        op_valid = 1'b0;
        chk("boo_sel", 8'(sound_sel), 8'b10);

        repeat (4) step();
        chk("boo_done", 8'(sound_on), 8'd0);

        send(4'b1110);
        op_valid = 1'b0;
        chk("fog1", 8'(fog), 8'd1);
        chk("fog1_excl", 8'({sound_on, wave, jaw}), 8'd0);
        for (int i = 2; i <= 6; i++) begin
            step();
            chk($sformatf("fog%0d", i), 8'(fog), 8'd1);
        end
        step();
        chk("fog_end", 8'(fog), 8'd0);
        chk("fog_end_ready", 8'(op_ready), 8'd1);

        send(4'b1100);
        op_valid = 1'b0;
        chk("wave1", 8'({wave, jaw}), 8'b10);
        repeat (2) step();
        chk("wave3", 8'(wave), 8'd1);
        step();
        chk("wave_end", 8'(wave), 8'd0);

        send(4'b1101);
        op_valid = 1'b0;
        chk("jaw1", 8'({wave, jaw}), 8'b01);
        repeat (3) step();
        chk("jaw_end", 8'(jaw), 8'd0);

        send(4'b1110);
        op_valid = 1'b0;
        repeat (2) step();
        chk("fog3_pre", 8'(fog), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_fog", 8'(fog), 8'd0);
        chk("arst_powered", 8'(powered), 8'd0);
        chk("arst_color", 8'(color), 8'd0);
        chk("arst_ready", 8'(op_ready), 8'd1);
        step();
        rst = 1'b0;
        send(4'b0101);
        chk("arst_off_color", 8'(color), 8'd0);

        send(4'b0000);
        send(4'b0101);
        chk("purple", 8'(color), 8'b010);
        send(4'b0111);
        op_valid = 1'b0;
        chk("illegal_bad", 8'(bad_op), 8'd1);
        chk("illegal_color", 8'(color), 8'b010);
        chk("illegal_ready", 8'(op_ready), 8'd1);
        step();
        chk("illegal_pulse", 8'(bad_op), 8'd0);
        send(4'b0001);
        chk("reset_powered", 8'(powered), 8'd0);
        chk("reset_color", 8'(color), 8'd0);
        send(4'b1111);
        chk("off_illegal", 8'(bad_op), 8'd0);

        send(4'b0000);
        send(4'b0100);
        chk("b2b_green", 8'(color), 8'b001);
        send(4'b0101);
        chk("b2b_purple", 8'(color), 8'b010);
        send(4'b0110);
        chk("b2b_orange", 8'(color), 8'b100);
        op_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
